pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the MIPS datapath (ALU add/sub/slt and branch-target paths).
- Splits a WIDTH-bit operation into 4-bit lookahead groups and spends one register stage per group. This allows wide operands at high clock rates.
- Uses a valid/ready handshake so the execute stage can stall it.
- Also produces carry-out, signed overflow and zero flags.

---
 rtl/mips_arith_pkg.sv | 17 +
 rtl/cla_group4.sv | 34 +++
 rtl/pipelined_cla_adder.sv | 170 +++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_arith_pkg.sv
// Shared arithmetic definitions for the MIPS datapath adders.
// The group width is fixed and the derived stage count is checked at elaboration.
package mips_arith_pkg;

    localparam int GROUP_W = 4;

    typedef logic [GROUP_W-1:0] grp_t;

    // Returns 0 for an illegal width so the instantiating module can raise an elaboration error.
    function automatic int calc_ngrp(input int width);
        if (width < GROUP_W || (width % GROUP_W) != 0) begin
            return 0;
        end
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum nibble, group carry-out,
// carry into the group MSB, and group generate/propagate.
module cla_group4
    import mips_arith_pkg::*;
(
    input  grp_t a,
    input  grp_t b,
    input  logic ci,
    output grp_t s,
    output logic co,
    output logic c3,
    output logic G,
    output logic P
);

    grp_t g;
    grp_t p;
    logic c1;
    logic c2;

    assign g  = a & b;
    assign p  = a ^ b;

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign G  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P  = &p;
    assign co = G | (P & ci);

    assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage,
// operands skewed in and result nibbles deskewed out so a whole word emerges per cycle.
module pipelined_cla_adder
    import mips_arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = GROUP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = calc_ngrp(WIDTH);
    localparam int LAST = NGRP - 1;

    if (GROUP != GROUP_W || NGRP == 0) begin : g_bad_param
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of 4 and GROUP must be 4");
    end

    // Handshake: input transfers on in_valid & in_ready, output on out_valid & out_ready.
    // The whole pipe advances together when the output slot is empty or being drained,
    // so in_ready follows out_ready combinationally and a held result never changes.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    assign adv      = ~valid_q | out_ready;
    assign in_ready = adv;
    assign b_eff    = b ^ {WIDTH{op_sub}};

    for (genvar k = 0; k < NGRP; k++) begin : grp
        grp_t ga;
        grp_t gb;
        grp_t gs;
        logic gci;
        logic gco;
        logic gc3;
        logic gg;
        logic gp;
        logic unused_gp;

        if (k == 0) begin : g_src
            assign ga  = a[GROUP_W-1:0];
            assign gb  = b_eff[GROUP_W-1:0];
            assign gci = op_sub | cin;
        end else begin : g_src
            assign ga  = fwd[k-1].a_q[GROUP_W-1:0];
            assign gb  = fwd[k-1].b_q[GROUP_W-1:0];
            assign gci = pipe[k-1].c_q;
        end

        cla_group4 u_cla (
            .a  (ga),
            .b  (gb),
            .ci (gci),
            .s  (gs),
            .co (gco),
            .c3 (gc3),
            .G  (gg),
            .P  (gp)
        );

        // Only the top group's MSB carry feeds the overflow flag.
        assign unused_gp = gg ^ gp ^ gc3;
    end

    // Operand skew: after stage k only the groups above k still need to travel.
    for (genvar k = 0; k < NGRP - 1; k++) begin : fwd
        localparam int RW = WIDTH - (k + 1) * GROUP_W;
        logic [RW-1:0] a_q;
        logic [RW-1:0] b_q;
        logic [RW-1:0] a_d;
        logic [RW-1:0] b_d;

        if (k == 0) begin : g_src
            assign a_d = a[WIDTH-1:GROUP_W];
            assign b_d = b_eff[WIDTH-1:GROUP_W];
        end else begin : g_src
            assign a_d = fwd[k-1].a_q[RW+GROUP_W-1:GROUP_W];
            assign b_d = fwd[k-1].b_q[RW+GROUP_W-1:GROUP_W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (adv) begin
                a_q <= a_d;
                b_q <= b_d;
            end
        end
    end

    // Result deskew: finished nibbles accumulate beneath the newest one.
    for (genvar k = 0; k < NGRP - 1; k++) begin : pipe
        localparam int DW = (k + 1) * GROUP_W;
        logic [DW-1:0] psum_q;
        logic [DW-1:0] psum_d;
        logic          c_q;
        logic          v_q;
        logic          v_d;

        if (k == 0) begin : g_src
            assign psum_d = grp[0].gs;
            assign v_d    = in_valid;
        end else begin : g_src
            assign psum_d = {grp[k].gs, pipe[k-1].psum_q};
            assign v_d    = pipe[k-1].v_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                psum_q <= '0;
                c_q    <= 1'b0;
                v_q    <= 1'b0;
            end else if (adv) begin
                psum_q <= psum_d;
                c_q    <= grp[k].gco;
                v_q    <= v_d;
            end
        end
    end

    logic [WIDTH-1:0] fin_sum_d;
    logic             fin_v_d;

    if (NGRP == 1) begin : g_fin
        assign fin_sum_d = grp[0].gs;
        assign fin_v_d   = in_valid;
    end else begin : g_fin
        assign fin_sum_d = {grp[LAST].gs, pipe[LAST-1].psum_q};
        assign fin_v_d   = pipe[LAST-1].v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (adv) begin
            sum_q   <= fin_sum_d;
            cout_q  <= grp[LAST].gco;
            ovf_q   <= grp[LAST].gc3 ^ grp[LAST].gco;
            valid_q <= fin_v_d;
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = valid_q & ~|sum_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed boundary cases, full-rate burst,
// stall hold, random backpressure against a scoreboard, and asynchronous reset flush.
module tb_pipelined_cla_adder;

    localparam int WIDTH = 32;
    localparam int NGRP  = WIDTH / 4;
    localparam int EW    = WIDTH + 3;

    localparam longint MAXS = (longint'(1) << (WIDTH - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected results, packed as {ovf, cout, zero, sum}.
    logic [EW-1:0] exp_q[$];

    pipelined_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic ci, input logic sub);
        longint           sx;
        longint           sy;
        longint           r;
        logic [WIDTH:0]   u;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sub) begin
            r = sx - sy;
            u = {1'b0, x} - {1'b0, y};
            c = (x >= y);
        end else begin
            r = sx + sy + longint'(ci);
            u = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            c = u[WIDTH];
        end
        s = u[WIDTH-1:0];
        v = (r > MAXS) || (r < MINS);
        return {v, c, (s == '0), s};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, op_sub));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {ovf, cout, zero, sum}, '0);
                end else begin
                    check("result", {ovf, cout, zero, sum}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom());
        endcase
    endfunction

    task automatic drive_rand();
        a      = pick();
        b      = pick();
        cin    = 1'($urandom_range(0, 1));
        op_sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_one(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xc, input logic xs, input logic [WIDTH-1:0] e_sum,
                           input logic e_cout, input logic e_ovf, input logic e_zero);
        int lat;
        a = xa; b = xb; cin = xc; op_sub = xs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, NGRP);
        check({tag, "_sum"}, sum, e_sum);
        check({tag, "_cout"}, cout, e_cout);
        check({tag, "_ovf"}, ovf, e_ovf);
        check({tag, "_zero"}, zero, e_zero);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        @(posedge clk); #1;
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int            cnt;
        int            first;
        int            last;
        int            sent;
        int            guard;
        logic          acc;
        logic [63:0]   snap;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {sum, cout, ovf, zero}, '0);
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("idle_no_valid", cnt, 0);
        @(posedge clk); #1;

        // Directed boundary cases
        run_one("ripple_all", '1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        run_one("ripple_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_one("sub_borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_minneg", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_zero", 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

        // Back-to-back burst of 100 at full rate
        out_ready = 1'b1;
        first = -1; last = -1; cnt = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    drive_rand();
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 140; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (first < 0) first = i;
                        cnt++;
                        last = i;
                    end
                end
            end
        join
        check("burst_first_cycle", first, NGRP);
        check("burst_count", cnt, 100);
        check("burst_contiguous", last - first + 1, 100);
        @(posedge clk); #1;

        // Fill the pipe, then stall the output for 5 cycles
        out_ready = 1'b1;
        for (int i = 0; i < NGRP; i++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        drive_rand();
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, ovf, cout, zero, sum};
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_hold", {out_valid, ovf, cout, zero, sum}, snap);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive_rand();
        end
        drain("stall_drain");

        // Randomised backpressure over 1000 operations
        sent = 0; guard = 0;
        drive_rand();
        in_valid = 1'b1;
        while (sent < 1000 && guard < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) sent++;
            if (acc || !in_valid) begin
                if (sent < 1000 && $urandom_range(0, 4) != 0) begin
                    drive_rand();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("rand_sent", sent, 1000);
        drain("rand_drain");

        // Reset with four operations in flight and one waiting at the output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("rst_fill_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_ready", in_ready, 1);
        check("rst_async_outputs", {sum, cout, ovf, zero}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_no_ghost", cnt, 0);
        @(posedge clk); #1;

        run_one("post_rst", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
